// File: rtl/mem_copy_engine_if.sv
// Bus bundle between a memory copy engine and its host: copy request,
// byte-wide memory port and completion status.
interface mem_copy_engine_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;
    logic [WIDTH-1:0] len;
    logic [WIDTH-1:0] memdata;
    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] checksum;

    // Host side: issues requests and returns memory read data.
    modport master (
        output start, src, dst, len, memdata,
        input  memread, memwrite, adr, writedata, busy, done, checksum
    );

    modport slave (
        input  start, src, dst, len, memdata,
        output memread, memwrite, adr, writedata, busy, done, checksum
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Byte-serial memory copy engine: alternates read and write cycles, copying
// forward from src to dst while accumulating a modular checksum of the bytes.
module mem_copy_engine #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    mem_copy_engine_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] dst_q, dst_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] byteBuf_q, byteBuf_d;
    logic [WIDTH-1:0] checksum_q, checksum_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            byteBuf_q  <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            byteBuf_q  <= byteBuf_d;
            checksum_q <= checksum_d;
        end
    end

    // Bus outputs depend only on registered state, so reset clears them at once.
    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        len_d         = len_q;
        idx_d         = idx_q;
        byteBuf_d     = byteBuf_q;
        checksum_d    = checksum_q;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.adr       = '0;
        bus.writedata = '0;
        bus.done      = 1'b0;
        bus.busy      = (state_q != IDLE);
        bus.checksum  = checksum_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d      = bus.src;
                    dst_d      = bus.dst;
                    len_d      = bus.len;
                    idx_d      = '0;
                    checksum_d = '0;
                    state_d    = (bus.len != '0) ? READ : DONE;
                end
            end
            READ: begin
                bus.memread = 1'b1;
                bus.adr     = src_q + idx_q;
                byteBuf_d   = bus.memdata;
                checksum_d  = checksum_q + bus.memdata;
                state_d     = WRITE;
            end
            WRITE: begin
                bus.memwrite  = 1'b1;
                bus.adr       = dst_q + idx_q;
                bus.writedata = byteBuf_q;
                idx_d         = idx_q + 1'b1;
                state_d       = (idx_d == len_q) ? DONE : READ;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter WIDTH, default 8, sets the byte-address and data width of the memory bus.
REQ-002 clk  input  1  sole clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a copy; sampled on the rising edge of clk.
REQ-005 src  input  WIDTH  source start byte address; captured when start is accepted.
REQ-006 dst  input  WIDTH  destination start byte address; captured when start is accepted.
REQ-007 len  input  WIDTH  byte count, 0..2^WIDTH-1; captured when start is accepted.
REQ-008 memdata  input  WIDTH  read data from memory, combinational from adr.
REQ-009 memread  output  1  read strobe.
REQ-010 memwrite  output  1  write strobe; memory writes writedata to adr on the next rising edge.
REQ-011 adr  output  WIDTH  byte address.
REQ-012 writedata  output  WIDTH  write data.
REQ-013 busy  output  1  high from the cycle after start is accepted until DONE is exited.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 checksum  output  WIDTH  mod-2^WIDTH sum of all bytes copied in the last or current operation.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, WRITE and DONE; all outputs SHALL be decoded from registered state only, with no combinational path from input to output.
REQ-017 IDLE: start=1 -> latch src, dst and len, clear idx and checksum, then go to READ if len!=0, else to DONE.
REQ-018 READ: memread=1, memwrite=0, adr=src_q+idx; at the edge, capture memdata into buf, add memdata to checksum, and go to WRITE.
REQ-019 WRITE: memwrite=1, memread=0, adr=dst_q+idx, writedata=buf; at the edge, idx+=1; go to DONE if idx+1==len_q, else to READ.
REQ-020 DONE: done=1 for exactly one cycle, then go to IDLE; busy=1 in READ, WRITE and DONE.
REQ-021 Timing: a copy of N bytes SHALL occupy 2N cycles in READ/WRITE plus 1 cycle in DONE; the done pulse SHALL appear 2N+1 cycles after the start edge.
REQ-022 Address arithmetic SHALL wrap modulo 2^WIDTH; for example, src=0xFE with len=3 reads 0xFE, 0xFF and then 0x00.
REQ-023 start SHALL be ignored in every state other than IDLE; changes to src, dst or len after acceptance SHALL have no effect.
REQ-024 Overlapping regions SHALL be copied forward, byte by byte, with no overlap detection.
REQ-025 In IDLE: memread=0, memwrite=0, adr=0, writedata=0; checksum SHALL hold its last value.
REQ-026 memread and memwrite SHALL never be high in the same cycle.

Reset
REQ-027 Reset asserted, including mid-copy, SHALL immediately force: state=IDLE, memread=0, memwrite=0, adr=0, writedata=0, busy=0, done=0, checksum=0, idx=0, buf=0.
REQ-028 No write SHALL complete at or after the edge coincident with reset assertion; an aborted copy SHALL produce no done pulse.
REQ-029 After reset is released, the first accepted start SHALL behave as in REQ-017.

Verification
(Bench memory: 2^WIDTH x 8 byte array, combinational read, write at posedge when memwrite=1.)
REQ-030 Basic copy: mem[0x10..0x13]={01,02,03,04}, start with src=0x10, dst=0x80, len=4 -> mem[0x80..0x83]={01,02,03,04}; done pulses 9 cycles after start; checksum=0x0A.
REQ-031 Zero length: start with len=0 -> no memread/memwrite; done pulses on the 2nd edge after start; checksum=0; busy high for exactly 1 cycle.
REQ-032 Wrap: mem[0xFE]=0xAA, mem[0xFF]=0xBB, mem[0x00]=0xCC; src=0xFE, dst=0x40, len=3 -> mem[0x40..0x42]={AA,BB,CC}; checksum=0x31.
REQ-033 Start while busy: a second start with different parameters during a 4-byte copy -> ignored; only the first copy occurs; exactly one done pulse.
REQ-034 Reset mid-copy: assert reset during the WRITE of byte 2 of a 4-byte copy -> outputs zero at once; only byte 1 is written at the destination; no done pulse; a new copy then completes correctly.
REQ-035 Overlap forward: mem[0x20..0x23]={11,22,33,44}; src=0x20, dst=0x21, len=3 -> mem[0x21..0x23]={11,11,11}.
